mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
Shares the single 32x32 `multiplier` instance among NUM_REQ requesters, for example LSTM gate lanes.
- Each cycle, a round-robin arbiter grants at most one valid request.
- The granted operands are muxed into the multiplier.
- A valid/ID pipeline runs alongside the multiplier, so the 64-bit product is returned tagged with the issuing requester ID.
- Sits between the gate/MAC sequencers and the multiplier datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
ID_W, $clog2(NUM_REQ), width of the requester ID. Derived; do not override.
MULT_LAT, 2, latency of `multiplier` in cycles (operand reg + product reg). Localparam, fixed.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_a  in  NUM_REQ*32  operand A, requester i at bits [32*i +: 32].
req_b  in  NUM_REQ*32  operand B, same packing as req_a.
req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] && req_ready[i].
rsp_valid  out  1  product valid (single-cycle pulse per issued request).
rsp_id  out  ID_W  requester ID of the product.
rsp_data  out  64  unsigned product a*b.
busy  out  1  high while any issued product is still in flight.

Behaviour:
- Reset (async): rr_ptr=NUM_REQ-1, so requester 0 has highest priority first. Valid pipeline cleared; rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. The multiplier's own registers also reset to 0.
- Arbitration (combinational):
  - Search starts at (rr_ptr+1) mod NUM_REQ and wraps.
  - The first index with req_valid set is granted.
  - req_ready is one-hot or all-zero.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Request rules: once asserted, req_valid and its operands stay stable until handshake.
- Pointer update: rr_ptr <= granted index on handshake; unchanged when no grant.
  - Requester i, after a grant, is lowest priority next cycle.
  - Any continuously requesting requester is granted within NUM_REQ cycles.
- Operand mux:
  - Granted requester's a/b drive the multiplier inputs.
  - With no grant, drive 0/0. The multiplier still runs but its product is ignored.
- Issue tracking:
  - On handshake in cycle T, v1 <= 1, id1 <= index at edge T.
  - At edge T+1, v2 <= v1, id2 <= id1.
  - rsp_valid=v2, rsp_id=id2, rsp_data=multiplier out_reg.
  - Result of a cycle-T handshake appears in cycle T+2 (latency MULT_LAT=2).
- Throughput: one product per cycle; back-to-back grants are fully pipelined.
- Response: no backpressure; consumers must accept rsp_valid on the cycle it is high. rsp_data is don't-care when rsp_valid=0.
- busy = v1 | v2.
- Arithmetic: unsigned 32x32 -> 64. 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001; no truncation.
- Simultaneous events: a new grant in the same cycle as an rsp_valid output is legal; the pipeline shifts every cycle.
- Reset mid-operation: in-flight products are discarded, no rsp_valid after reset deasserts, and the pointer returns to the reset value.
- NUM_REQ not a power of 2: the pointer wraps explicitly at NUM_REQ-1; IDs >= NUM_REQ are never produced.

Decomposition:
- Package mult_arb_pkg: MULT_LAT=2, OP_W=32, PROD_W=64, and the function clog2-based ID width helper.
- Sub-module rr_arbiter (parameter N): req vector, advance strobe -> one-hot grant, grant index; holds rr_ptr.
- mult_arbiter instantiates rr_arbiter and `multiplier`, and holds the operand mux and the valid/ID pipeline.

Test Plan:
1. Single request: req 2 valid with a=7, b=6, handshake at cycle T -> rsp_valid in T+2 with rsp_id=2, rsp_data=42, busy high in T+1..T+2.
2. All four requesters valid continuously with distinct operands, starting after reset -> grants in order 0,1,2,3,0,... at one per cycle; responses in the same order, each two cycles after its grant, values correct.
3. Requesters 1 and 3 valid; 1 drops after its grant -> grant sequence 1,3,3,3; rr_ptr is unchanged in idle cycles and the next grant to 1 is fair.
4. Max operands: a=b=0xFFFFFFFF on req 0 -> rsp_data=0xFFFFFFFE00000001, rsp_id=0.
5. Reset pulse asserted one cycle after two back-to-back grants -> no rsp_valid after release; outputs 0; first grant after reset goes to requester 0.
6. Random valid patterns with stable-until-handshake operands -> scoreboard by ID matches every product, no lost or duplicate responses, and no requester waits more than NUM_REQ cycles.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the multiplier arbiter slice.
// Fixes the operand/product widths and the multiplier pipeline depth.
package mult_arb_pkg;

    localparam int MULT_LAT = 2;
    localparam int OP_W     = 32;
    localparam int PROD_W   = 64;

    // A single requester would give $clog2 == 0, so keep at least one ID bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester/response bundle between the gate/MAC sequencers and mult_arbiter.
// master = requester side, slave = arbiter side.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [PROD_W-1:0]       rsp_data;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/multiplier.sv
// Unsigned 32x32 -> 64 multiplier with an operand register and a product register.
// Operands presented in cycle T produce out_reg in cycle T+2.
module multiplier
    import mult_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] out_reg
);

    logic [OP_W-1:0] a_q;
    logic [OP_W-1:0] b_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            out_reg <= '0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            out_reg <= PROD_W'(a_q) * PROD_W'(b_q);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after rr_ptr, wrapping at N-1.
// The pointer moves to the granted index when advance is strobed.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] rr_ptr;
    int            cand;

    // NOTE: every output of this combinational block gets a default first, so
    // no path leaves a value held and no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 1; k <= N; k++) begin
            // Explicit wrap keeps non-power-of-two N from producing IDs >= N.
            cand = int'(rr_ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
        if (grant_valid) begin
            grant = N'(1) << grant_idx;
        end
    end

    // Starting at N-1 makes requester 0 the first in line after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= IW'(N - 1);
        end else if (advance && grant_valid) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one 32x32 multiplier among NUM_REQ requesters with round-robin issue.
// A valid/ID pipeline tracks each issued product so it returns tagged with its requester.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic               handshake;
    logic [OP_W-1:0]    mul_a;
    logic [OP_W-1:0]    mul_b;
    logic [PROD_W-1:0]  product;
    logic               v1;
    logic               v2;
    logic [ID_W-1:0]    id1;
    logic [ID_W-1:0]    id2;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req_valid),
        .advance     (handshake),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Grant is derived from req_valid, so any grant is also a handshake.
    assign bus.req_ready = grant;
    assign handshake     = |(bus.req_valid & grant);

    // Idle cycles feed zeros; the resulting product is never flagged valid.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant_valid) begin
            mul_a = bus.req_a[OP_W*grant_idx +: OP_W];
            mul_b = bus.req_b[OP_W*grant_idx +: OP_W];
        end
    end

    multiplier u_mul (
        .clk     (clk),
        .reset   (reset),
        .a       (mul_a),
        .b       (mul_b),
        .out_reg (product)
    );

    // Two stages mirror the multiplier's operand and product registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            id1 <= '0;
            id2 <= '0;
        end else begin
            v1  <= handshake;
            id1 <= grant_idx;
            v2  <= v1;
            id2 <= id1;
        end
    end

    assign bus.rsp_valid = v2;
    assign bus.rsp_id    = id2;
    assign bus.rsp_data  = product;
    assign bus.busy      = v1 | v2;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized bench for mult_arbiter with a queue-based reference model.
// Grants follow a "search after last winner" rule; products are due two cycles after issue.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int N = 4;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_arbiter_if #(.NUM_REQ(N)) bus ();

    mult_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          last  = N - 1;
    exp_t        pend[$];
    logic        mv[N];
    logic [31:0] ma[N];
    logic [31:0] mb[N];
    int          waitc[N];
    int          granted;
    logic        seen_v;
    int          seen_id;
    logic [63:0] seen_d;
    int          gseq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]      = mv[i];
            bus.req_a[32*i +: 32] = ma[i];
            bus.req_b[32*i +: 32] = mb[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
            mb[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        mv[i] = 1'b1;
        ma[i] = a;
        mb[i] = b;
    endtask

    // Reset (async) wipes in-flight work; the model forgets everything too.
    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        apply_inputs();
        pend.delete();
        last = N - 1;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
    endtask

    // One clock cycle: drive, check at negedge against the model, advance.
    task automatic step();
        exp_t e;
        logic exp_v;
        int   g;
        apply_inputs();
        @(negedge clk);
        exp_v = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e     = pend.pop_front();
            exp_v = 1'b1;
        end
        check("rsp_valid", bus.rsp_valid, exp_v);
        if (exp_v) begin
            check("rsp_id", bus.rsp_id, e.id);
            check("rsp_data", bus.rsp_data, e.data);
        end
        seen_v  = bus.rsp_valid;
        seen_id = int'(bus.rsp_id);
        seen_d  = bus.rsp_data;
        check("busy", bus.busy, exp_v || pend.size() > 0);

        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && mv[(last + k) % N]) g = (last + k) % N;
        end
        check("req_ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        for (int i = 0; i < N; i++) begin
            if (i == g) begin
                check("wait_bound", waitc[i] < N, 1);
                waitc[i] = 0;
            end else if (mv[i]) begin
                waitc[i]++;
            end
        end
        if (g >= 0) begin
            pend.push_back('{id: g, data: 64'(ma[g]) * 64'(mb[g]), due: cyc + 2});
            last = g;
        end
        granted = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        clear_reqs();
        apply_inputs();
        for (int i = 0; i < N; i++) waitc[i] = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: single request from requester 2.
        set_req(2, 32'd7, 32'd6);
        step();
        check("t1_grant", granted, 2);
        mv[2] = 1'b0;
        step();
        step();
        check("t1_valid", seen_v, 1);
        check("t1_id", seen_id, 2);
        check("t1_data", seen_d, 64'd42);

        // 2: all requesters continuously valid from reset.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
        gseq.delete();
        for (int k = 0; k < 2 * N; k++) begin
            step();
            gseq.push_back(granted);
            if (granted >= 0) set_req(granted, $urandom, $urandom);
        end
        for (int k = 0; k < 2 * N; k++) check("t2_order", gseq[k], k % N);
        clear_reqs();
        repeat (2) step();

        // 3: requesters 1 and 3; 1 drops after its grant.
        set_req(1, 32'd11, 32'd13);
        set_req(3, 32'd17, 32'd19);
        gseq.delete();
        for (int k = 0; k < 4; k++) begin
            step();
            gseq.push_back(granted);
            if (granted == 1) mv[1] = 1'b0;
            if (granted == 3) set_req(3, $urandom, $urandom);
        end
        check("t3_g0", gseq[0], 1);
        check("t3_g1", gseq[1], 3);
        check("t3_g2", gseq[2], 3);
        check("t3_g3", gseq[3], 3);
        clear_reqs();
        repeat (2) step();
        set_req(1, 32'd2, 32'd3);
        set_req(3, 32'd5, 32'd7);
        step();
        check("t3_fair1", granted, 1);
        mv[1] = 1'b0;
        step();
        check("t3_fair3", granted, 3);
        clear_reqs();
        repeat (2) step();

        // 4: maximum operands.
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        check("t4_grant", granted, 0);
        mv[0] = 1'b0;
        step();
        step();
        check("t4_valid", seen_v, 1);
        check("t4_id", seen_id, 0);
        check("t4_data", seen_d, 64'hFFFF_FFFE_0000_0001);

        // 5: reset one cycle after two back-to-back grants.
        set_req(0, 32'd100, 32'd3);
        set_req(1, 32'd200, 32'd5);
        step();
        if (granted >= 0) mv[granted] = 1'b0;
        step();
        do_reset();
        step();
        check("t5_quiet0", seen_v, 0);
        step();
        check("t5_quiet1", seen_v, 0);
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(i + 9));
        step();
        check("t5_first", granted, 0);
        clear_reqs();
        repeat (3) step();

        // 6: random traffic, operands held until handshake.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 7) == 0) set_req(i, 32'hFFFF_FFFF, $urandom);
                    else set_req(i, $urandom, $urandom);
                end
            end
            step();
            if (granted >= 0) mv[granted] = 1'b0;
        end
        clear_reqs();
        repeat (3) step();
        check("t6_drained", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
